// File: rtl/f2c_queue_scheduler_if.sv
// Request / grant / completion handshake between the PDU buffer, the scheduler and the f2c DMA engine.
interface f2c_queue_scheduler_if #(
    parameter int unsigned NB_QUEUES = 4,
    parameter int unsigned RB_AWIDTH = 16
);
    localparam int unsigned QW = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1;

    logic                 req_valid;
    logic [RB_AWIDTH-1:0] req_size;
    logic                 req_ready;
    logic                 grant_valid;
    logic                 grant_ready;
    logic [QW-1:0]        grant_qid;
    logic [RB_AWIDTH-1:0] grant_tail;
    logic [RB_AWIDTH-1:0] grant_head;
    logic [63:0]          grant_kmem_addr;
    logic [RB_AWIDTH-1:0] grant_size;
    logic                 dma_done;
    logic [RB_AWIDTH-1:0] dma_new_tail;

    // Requester / DMA-engine side
    modport master (
        output req_valid, req_size, grant_ready, dma_done, dma_new_tail,
        input  req_ready, grant_valid, grant_qid, grant_tail, grant_head,
               grant_kmem_addr, grant_size
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_size, grant_ready, dma_done, dma_new_tail,
        output req_ready, grant_valid, grant_qid, grant_tail, grant_head,
               grant_kmem_addr, grant_size
    );
endinterface

// File: rtl/f2c_queue_scheduler.sv
// Round-robin FPGA->CPU DMA queue scheduler: grants the next queue whose ring has room
// for the pending transfer and owns each queue's tail pointer.
module f2c_queue_scheduler #(
    parameter  int unsigned NB_QUEUES = 4,
    parameter  int unsigned RB_AWIDTH = 16,
    localparam int unsigned QW        = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1
) (
    input  logic                           pcie_clk,
    input  logic                           pcie_reset_n,
    input  logic                           disable_sched,
    input  logic [QW:0]                    total_queues,
    input  logic [RB_AWIDTH:0]             rb_size,
    input  logic [NB_QUEUES*RB_AWIDTH-1:0] heads_flat,
    input  logic [NB_QUEUES*64-1:0]        kmem_flat,
    output logic [NB_QUEUES*RB_AWIDTH-1:0] tails_flat,
    output logic                           busy,
    output logic [31:0]                    stall_cnt,
    output logic                           err_done,
    f2c_queue_scheduler_if.slave           bus
);
    localparam int unsigned NQW    = QW + 1;
    localparam int unsigned NRB    = RB_AWIDTH + 1;
    localparam logic [QW:0] NQ_MAX = NQW'(NB_QUEUES);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [RB_AWIDTH-1:0] tails_q [NB_QUEUES];
    logic [RB_AWIDTH-1:0] tails_d [NB_QUEUES];
    logic [QW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [QW-1:0]        scan_ptr_q, scan_ptr_d;
    logic [QW:0]          scan_cnt_q, scan_cnt_d;
    logic [QW:0]          nq_q, nq_d;
    logic [31:0]          stall_q, stall_d;
    logic                 req_ready_q, req_ready_d;
    logic                 grant_valid_q, grant_valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [QW-1:0]        gqid_q, gqid_d;
    logic [RB_AWIDTH-1:0] gtail_q, gtail_d;
    logic [RB_AWIDTH-1:0] ghead_q, ghead_d;
    logic [RB_AWIDTH-1:0] gsize_q, gsize_d;
    logic [63:0]          gkmem_q, gkmem_d;

    logic [RB_AWIDTH-1:0] heads [NB_QUEUES];
    logic [63:0]          kmems [NB_QUEUES];

    logic [QW:0]          nq_in;
    logic [QW-1:0]        rr_start_in, rr_start_cur;
    logic [RB_AWIDTH-1:0] mask, free_scan;
    logic                 eligible, scan_wrap, scan_pass_end, qid_wrap;

    // Unpack flat CPU-register buses and pack the tail array back out
    for (genvar i = 0; i < NB_QUEUES; i++) begin : g_flat
        assign heads[i] = heads_flat[i*RB_AWIDTH +: RB_AWIDTH];
        assign kmems[i] = kmem_flat[i*64 +: 64];
        assign tails_flat[i*RB_AWIDTH +: RB_AWIDTH] = tails_q[i];
    end

    // Active queue count: 0 means one queue, clipped to the number of built queues
    assign nq_in = (total_queues == '0)    ? NQW'(1) :
                   (total_queues > NQ_MAX) ? NQ_MAX  : total_queues;

    // A stale rr_ptr beyond a shrunk queue count restarts the scan at queue 0
    assign rr_start_in  = ({1'b0, rr_ptr_q} < nq_in) ? rr_ptr_q : '0;
    assign rr_start_cur = ({1'b0, rr_ptr_q} < nq_q)  ? rr_ptr_q : '0;

    // Free space in the scanned ring, one slot kept empty to tell full from empty
    assign mask      = RB_AWIDTH'(rb_size - NRB'(1));
    assign free_scan = (heads[scan_ptr_q] - tails_q[scan_ptr_q] - RB_AWIDTH'(1)) & mask;
    assign eligible  = (bus.req_size == '0) || (free_scan >= bus.req_size);

    assign scan_wrap     = (NQW'({1'b0, scan_ptr_q}) + NQW'(1)) == nq_q;
    assign scan_pass_end = scan_cnt_q == (nq_q - NQW'(1));
    assign qid_wrap      = (NQW'({1'b0, gqid_q}) + NQW'(1)) == nq_q;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        tails_d       = tails_q;
        rr_ptr_d      = rr_ptr_q;
        scan_ptr_d    = scan_ptr_q;
        scan_cnt_d    = scan_cnt_q;
        nq_d          = nq_q;
        stall_d       = stall_q;
        req_ready_d   = 1'b0;
        err_d         = err_q;
        gqid_d        = gqid_q;
        gtail_d       = gtail_q;
        ghead_d       = ghead_q;
        gsize_d       = gsize_q;
        gkmem_d       = gkmem_q;

        if (bus.dma_done && (state_q != WAIT_DONE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !disable_sched) begin
                    state_d    = SCAN;
                    nq_d       = nq_in;
                    scan_ptr_d = rr_start_in;
                    scan_cnt_d = '0;
                end
            end
            SCAN: begin
                if (!bus.req_valid) begin
                    state_d = IDLE;
                end else if (eligible) begin
                    state_d = ISSUE;
                    gqid_d  = scan_ptr_q;
                    gtail_d = tails_q[scan_ptr_q];
                    ghead_d = heads[scan_ptr_q];
                    gkmem_d = kmems[scan_ptr_q];
                    gsize_d = bus.req_size;
                end else if (scan_pass_end) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 32'd1;
                    end
                    scan_ptr_d = rr_start_cur;
                    scan_cnt_d = '0;
                end else begin
                    scan_ptr_d = scan_wrap ? '0 : scan_ptr_q + QW'(1);
                    scan_cnt_d = scan_cnt_q + NQW'(1);
                end
            end
            ISSUE: begin
                if (bus.grant_ready) begin
                    state_d     = WAIT_DONE;
                    req_ready_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.dma_done) begin
                    tails_d[gqid_q] = bus.dma_new_tail;
                    rr_ptr_d        = qid_wrap ? '0 : gqid_q + QW'(1);
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_valid_d = (state_d == ISSUE);
        busy_d        = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any in-flight grant immediately
    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            state_q       <= IDLE;
            for (int i = 0; i < NB_QUEUES; i++) begin
                tails_q[i] <= '0;
            end
            rr_ptr_q      <= '0;
            scan_ptr_q    <= '0;
            scan_cnt_q    <= '0;
            nq_q          <= NQW'(1);
            stall_q       <= '0;
            req_ready_q   <= 1'b0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            gqid_q        <= '0;
            gtail_q       <= '0;
            ghead_q       <= '0;
            gsize_q       <= '0;
            gkmem_q       <= '0;
        end else begin
            state_q       <= state_d;
            tails_q       <= tails_d;
            rr_ptr_q      <= rr_ptr_d;
            scan_ptr_q    <= scan_ptr_d;
            scan_cnt_q    <= scan_cnt_d;
            nq_q          <= nq_d;
            stall_q       <= stall_d;
            req_ready_q   <= req_ready_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            gqid_q        <= gqid_d;
            gtail_q       <= gtail_d;
            ghead_q       <= ghead_d;
            gsize_q       <= gsize_d;
            gkmem_q       <= gkmem_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.grant_valid     = grant_valid_q;
    assign bus.grant_qid       = gqid_q;
    assign bus.grant_tail      = gtail_q;
    assign bus.grant_head      = ghead_q;
    assign bus.grant_size      = gsize_q;
    assign bus.grant_kmem_addr = gkmem_q;
    assign busy                = busy_q;
    assign stall_cnt           = stall_q;
    assign err_done            = err_q;
endmodule

// File: tb/tb_f2c_queue_scheduler.sv
// Bench for f2c_queue_scheduler: directed scenarios plus randomized transactions
// checked against a ring-arithmetic round-robin reference model.
module tb_f2c_queue_scheduler;
    localparam int unsigned NB_QUEUES = 4;
    localparam int unsigned RB_AWIDTH = 16;
    localparam int unsigned QW        = 2;

    logic                           pcie_clk = 1'b0;
    logic                           pcie_reset_n;
    logic                           disable_sched;
    logic [QW:0]                    total_queues;
    logic [RB_AWIDTH:0]             rb_size;
    logic [RB_AWIDTH-1:0]           heads [NB_QUEUES];
    logic [63:0]                    kmem [NB_QUEUES];
    logic [NB_QUEUES*RB_AWIDTH-1:0] heads_flat;
    logic [NB_QUEUES*64-1:0]        kmem_flat;
    logic [NB_QUEUES*RB_AWIDTH-1:0] tails_flat;
    logic                           busy;
    logic [31:0]                    stall_cnt;
    logic                           err_done;

    f2c_queue_scheduler_if #(.NB_QUEUES(NB_QUEUES), .RB_AWIDTH(RB_AWIDTH)) bus ();

    f2c_queue_scheduler #(.NB_QUEUES(NB_QUEUES), .RB_AWIDTH(RB_AWIDTH)) dut (
        .pcie_clk     (pcie_clk),
        .pcie_reset_n (pcie_reset_n),
        .disable_sched(disable_sched),
        .total_queues (total_queues),
        .rb_size      (rb_size),
        .heads_flat   (heads_flat),
        .kmem_flat    (kmem_flat),
        .tails_flat   (tails_flat),
        .busy         (busy),
        .stall_cnt    (stall_cnt),
        .err_done     (err_done),
        .bus          (bus)
    );

    always #5 pcie_clk = ~pcie_clk;

    for (genvar i = 0; i < NB_QUEUES; i++) begin : g_pack
        assign heads_flat[i*RB_AWIDTH +: RB_AWIDTH] = heads[i];
        assign kmem_flat[i*64 +: 64]                = kmem[i];
    end

    // Reference model state
    int m_tails [NB_QUEUES];
    int m_rr;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge pcie_clk);
    endtask

    function automatic int m_nq();
        int t = int'(total_queues);
        if (t == 0) return 1;
        return (t > NB_QUEUES) ? NB_QUEUES : t;
    endfunction

    // Space left in ring q: distance from tail to head minus one slot, modulo ring size
    function automatic int m_free(input int q);
        int d = (int'(heads[q]) - m_tails[q] - 1) % 65536;
        if (d < 0) d += 65536;
        return d % int'(rb_size);
    endfunction

    // First queue with room, starting at the round-robin pointer; -1 if none
    function automatic int m_pick(output int skips);
        int nq    = m_nq();
        int start = (m_rr < nq) ? m_rr : 0;
        int rs    = int'(bus.req_size);
        skips = 0;
        for (int k = 0; k < nq; k++) begin
            int q = (start + k) % nq;
            if (rs == 0 || m_free(q) >= rs) begin
                skips = k;
                return q;
            end
        end
        return -1;
    endfunction

    task automatic wait_grant(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < budget && !ok) begin
            tick();
            lat++;
            if (bus.grant_valid) ok = 1'b1;
        end
    endtask

    // Handshake the grant, finish the DMA, check the tail update
    task automatic complete(input int q, input int new_tail, input int nq);
        bus.grant_ready = 1'b1;
        tick();
        check("req_ready", 64'(bus.req_ready), 64'(1));
        check("grant_drop", 64'(bus.grant_valid), 64'(0));
        bus.grant_ready = 1'b0;
        bus.req_valid   = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        check("busy_wait", 64'(busy), 64'(1));
        bus.dma_new_tail = RB_AWIDTH'(new_tail);
        bus.dma_done     = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        m_tails[q] = new_tail;
        m_rr       = (q + 1) % nq;
        check("tail", 64'(tails_flat[q*RB_AWIDTH +: RB_AWIDTH]), 64'(new_tail));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    // Request already raised at this negedge; wait, compare the grant fields, complete
    task automatic await_txn(input bit chk_lat, input int new_tail);
        int  skips, q, lat, nq;
        bit  ok;
        nq = m_nq();
        q  = m_pick(skips);
        wait_grant(40, lat, ok);
        check("grant_seen", 64'(ok), 64'(1));
        if (!ok) begin
            bus.req_valid = 1'b0;
            tick();
            return;
        end
        if (chk_lat) check("latency", 64'(lat), 64'(2 + skips));
        check("qid", 64'(bus.grant_qid), 64'(q));
        check("gtail", 64'(bus.grant_tail), 64'(m_tails[q]));
        check("ghead", 64'(bus.grant_head), 64'(heads[q]));
        check("gkmem", bus.grant_kmem_addr, kmem[q]);
        check("gsize", 64'(bus.grant_size), 64'(bus.req_size));
        complete(q, new_tail, nq);
    endtask

    task automatic txn(input int new_tail);
        bus.req_valid = 1'b1;
        await_txn(1'b1, new_tail);
    endtask

    task automatic heads_to_tails();
        for (int q = 0; q < NB_QUEUES; q++) heads[q] = RB_AWIDTH'(m_tails[q]);
    endtask

    initial begin
        int         skips;
        int         pick;
        logic [31:0] prev;

        pcie_reset_n     = 1'b0;
        disable_sched    = 1'b0;
        total_queues     = 3'd4;
        rb_size          = 17'd1024;
        bus.req_valid    = 1'b0;
        bus.req_size     = '0;
        bus.grant_ready  = 1'b0;
        bus.dma_done     = 1'b0;
        bus.dma_new_tail = '0;
        for (int q = 0; q < NB_QUEUES; q++) begin
            heads[q]   = '0;
            kmem[q]    = {$urandom, $urandom};
            m_tails[q] = 0;
        end
        m_rr = 0;

        repeat (3) tick();
        check("rst_grant_valid", 64'(bus.grant_valid), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err_done), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_tails", 64'(tails_flat), 64'(0));
        check("rst_qid", 64'(bus.grant_qid), 64'(0));
        pcie_reset_n = 1'b1;
        tick();

        // Plain rotation across four roomy rings
        bus.req_size = 16'd8;
        for (int i = 0; i < 5; i++) txn(8 * (i + 1));

        // Queue 1 full while it is next in line
        heads[1] = RB_AWIDTH'(m_tails[1] + 1);
        txn(100);

        // Every ring full: scanning stalls until a head moves
        for (int q = 0; q < NB_QUEUES; q++) heads[q] = RB_AWIDTH'(m_tails[q] + 1);
        bus.req_valid = 1'b1;
        repeat (20) tick();
        check("stall_no_grant", 64'(bus.grant_valid), 64'(0));
        check("stall_counted", 64'(stall_cnt != 0), 64'(1));
        heads[3] = 16'd512;
        await_txn(1'b0, 200);

        // Wrap-around free space boundary on a single queue
        total_queues = 3'd1;
        heads_to_tails();
        txn(1020);
        heads[0]     = 16'd4;
        bus.req_size = 16'd7;
        txn(1020);
        bus.req_size  = 16'd8;
        prev          = stall_cnt;
        bus.req_valid = 1'b1;
        repeat (8) tick();
        check("free7_no_grant", 64'(bus.grant_valid), 64'(0));
        check("free7_stall", 64'(stall_cnt > prev), 64'(1));
        bus.req_valid = 1'b0;
        repeat (2) tick();
        check("abort_idle", 64'(busy), 64'(0));

        // Stray completion while idle
        bus.dma_new_tail = 16'd77;
        bus.dma_done     = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        check("err_done", 64'(err_done), 64'(1));
        check("stray_tail0", 64'(tails_flat[0 +: RB_AWIDTH]), 64'(m_tails[0]));

        // Zero active queues behaves as one
        total_queues = 3'd0;
        for (int i = 0; i < 3; i++) begin
            heads_to_tails();
            txn(int'($urandom_range(0, 65535)));
        end

        // Disabled scheduler holds off a pending request
        total_queues  = 3'd4;
        heads_to_tails();
        disable_sched = 1'b1;
        bus.req_valid = 1'b1;
        repeat (6) tick();
        check("dis_no_grant", 64'(bus.grant_valid), 64'(0));
        check("dis_idle", 64'(busy), 64'(0));
        disable_sched = 1'b0;
        await_txn(1'b1, 300);

        // Reset while a grant is outstanding
        heads_to_tails();
        bus.req_valid = 1'b1;
        repeat (4) tick();
        check("pre_rst_grant", 64'(bus.grant_valid), 64'(1));
        pcie_reset_n = 1'b0;
        #1;
        check("arst_grant_valid", 64'(bus.grant_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_err", 64'(err_done), 64'(0));
        check("arst_stall", 64'(stall_cnt), 64'(0));
        check("arst_tails", 64'(tails_flat), 64'(0));
        bus.req_valid = 1'b0;
        tick();
        pcie_reset_n = 1'b1;
        for (int q = 0; q < NB_QUEUES; q++) m_tails[q] = 0;
        m_rr = 0;
        heads_to_tails();
        tick();
        txn(16);

        // Randomized transactions
        for (int it = 0; it < 40; it++) begin
            total_queues = QW'(0) + 3'($urandom_range(0, 7));
            rb_size      = 17'(1) << $urandom_range(4, 10);
            bus.req_size = RB_AWIDTH'($urandom_range(0, int'(rb_size) / 2));
            for (int q = 0; q < NB_QUEUES; q++) begin
                case ($urandom_range(0, 3))
                    0:       heads[q] = RB_AWIDTH'(m_tails[q] + 1);
                    1:       heads[q] = RB_AWIDTH'(m_tails[q]);
                    default: heads[q] = RB_AWIDTH'($urandom_range(0, 65535));
                endcase
            end
            pick = m_pick(skips);
            if (pick < 0) begin
                pick        = int'($urandom_range(0, m_nq() - 1));
                heads[pick] = RB_AWIDTH'(m_tails[pick]);
            end
            txn(int'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
